linearb_deadlock_reporter: RTL and testbench

- Sits directly downstream of the per-instance HLS deadlock monitors in the lineArb design. Consumes their `block` outputs, one bit per monitor.
- Qualifies each bit by requiring it to persist for THRESHOLD consecutive cycles, then reports one deadlock event over a valid/ready record interface.
- After the report is accepted, holds a sticky deadlock flag until software clears it. This filters transient back-pressure that the monitors flag every cycle.

---
 rtl/linearb_dbg_pkg.sv | 27 ++
 rtl/linearb_persist_cnt.sv | 47 ++++
 rtl/linearb_deadlock_reporter.sv | 120 ++++++++++++
 tb/tb_linearb_deadlock_reporter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/linearb_dbg_pkg.sv
// Shared definitions for the lineArb deadlock reporting logic.
// Contents:
//   state_t       - reporter FSM states
//   IDX_W         - width of the reported monitor index
//   DEF_THRESHOLD - default persistence threshold in cycles
//   report_rec_t  - deadlock record (index, mask, timestamp) sized for the
//                   largest supported configuration; consumers slice it
package linearb_dbg_pkg;

    typedef enum logic [1:0] {
        S_MON    = 2'd0,
        S_REPORT = 2'd1,
        S_HELD   = 2'd2
    } state_t;

    localparam int IDX_W         = 5;
    localparam int DEF_THRESHOLD = 1024;
    localparam int MAX_MON       = 32;
    localparam int MAX_TS_W      = 64;

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [MAX_MON-1:0]  mask;
        logic [MAX_TS_W-1:0] ts;
    } report_rec_t;

endpackage

// File: rtl/linearb_persist_cnt.sv
// Saturating persistence counter for one deadlock monitor bit.
// Ports:
//   clock, reset - clock and synchronous active-high reset
//   clr          - restart the count from zero (wins over freeze)
//   freeze       - hold the count unchanged
//   inc          - monitor block bit; low restarts the count
//   qual         - count has reached THRESHOLD
module linearb_persist_cnt
    import linearb_dbg_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic freeze,
    input  logic inc,
    output logic qual
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(THRESHOLD);

    logic [CNT_W-1:0] cnt_r;

    // Count consecutive blocked cycles, saturating at the threshold.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (freeze) begin
            cnt_r <= cnt_r;
        end else if (inc) begin
            if (cnt_r == SAT) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign qual = (cnt_r == SAT);

endmodule

// File: rtl/linearb_deadlock_reporter.sv
// Qualifies HLS deadlock monitor block bits by persistence and reports one
// deadlock record over a valid/ready interface, then holds a sticky flag
// until software clears it.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   block_in       - one block bit per deadlock monitor
//   clear          - single-cycle pulse: drop sticky state, restart detection
//   report_valid   - record available; report_ready accepts it
//   report_idx     - lowest qualified monitor index (zero-extended)
//   report_mask    - all monitors qualified when the record was captured
//   report_ts      - free-running timestamp at capture
//   deadlock_flag  - record accepted and not yet cleared
module linearb_deadlock_reporter
    import linearb_dbg_pkg::*;
#(
    parameter int NUM_MON   = 4,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [NUM_MON-1:0] report_mask,
    output logic [TS_W-1:0]    report_ts,
    output logic               deadlock_flag
);

    state_t              state_r;
    logic [TS_W-1:0]     ts_r;
    logic [NUM_MON-1:0]  qual_s;
    logic [IDX_W-1:0]    low_idx_s;
    logic                freeze_s;

    // Counters only track persistence while watching for a new deadlock.
    assign freeze_s = (state_r != S_MON);

    for (genvar g = 0; g < NUM_MON; g++) begin : g_cnt
        linearb_persist_cnt #(
            .THRESHOLD (THRESHOLD),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clock  (clock),
            .reset  (reset),
            .clr    (clear),
            .freeze (freeze_s),
            .inc    (block_in[g]),
            .qual   (qual_s[g])
        );
    end

    // Free-running timestamp; only reset clears it, so records stay ordered across clears.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1'b1);
        end
    end

    // Lowest-index priority encoder: scan downward so the lowest set bit wins.
    always_comb begin
        low_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (qual_s[i]) begin
                low_idx_s = IDX_W'(i);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Reporter FSM with registered record and status outputs.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_r       <= S_MON;
            report_valid  <= 1'b0;
            report_idx    <= {IDX_W{1'b0}};
            report_mask   <= {NUM_MON{1'b0}};
            report_ts     <= {TS_W{1'b0}};
            deadlock_flag <= 1'b0;
        end else begin
            case (state_r)
                S_MON: begin
                    if (|qual_s) begin
                        state_r      <= S_REPORT;
                        report_valid <= 1'b1;
                        report_idx   <= low_idx_s;
                        report_mask  <= qual_s;
                        report_ts    <= ts_r;
                    end else begin
                        state_r <= S_MON;
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        state_r       <= S_HELD;
                        report_valid  <= 1'b0;
                        deadlock_flag <= 1'b1;
                    end else begin
                        state_r <= S_REPORT;
                    end
                end
                S_HELD: begin
                    state_r <= S_HELD;
                end
                default: begin
                    state_r       <= S_MON;
                    report_valid  <= 1'b0;
                    deadlock_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linearb_deadlock_reporter.sv
// Self-checking bench for linearb_deadlock_reporter (NUM_MON=4, THRESHOLD=4).
// A behavioural model tracks per-monitor persistence and the pending/held
// status of a record; every cycle the DUT outputs are compared against it.
module tb_linearb_deadlock_reporter;
    import linearb_dbg_pkg::*;

    localparam int NUM_MON   = 4;
    localparam int THRESHOLD = 4;
    localparam int CNT_W     = 3;
    localparam int TS_W      = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_MON-1:0] block_in = '0;
    logic               clear = 1'b0;
    logic               report_ready = 1'b0;
    logic               report_valid;
    logic [IDX_W-1:0]   report_idx;
    logic [NUM_MON-1:0] report_mask;
    logic [TS_W-1:0]    report_ts;
    logic               deadlock_flag;

    linearb_deadlock_reporter #(
        .NUM_MON   (NUM_MON),
        .THRESHOLD (THRESHOLD),
        .CNT_W     (CNT_W),
        .TS_W      (TS_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .block_in      (block_in),
        .clear         (clear),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_idx    (report_idx),
        .report_mask   (report_mask),
        .report_ts     (report_ts),
        .deadlock_flag (deadlock_flag)
    );

    always #5 clock = ~clock;

    // Behavioural model state
    int          m_cnt [NUM_MON];
    bit          m_pend;
    bit          m_held;
    report_rec_t m_rec;
    logic [TS_W-1:0] m_ts;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_update();
        logic [NUM_MON-1:0] q;
        bit busy;
        if (reset) begin
            for (int i = 0; i < NUM_MON; i++) m_cnt[i] = 0;
            m_pend = 0;
            m_held = 0;
            m_rec  = '0;
            m_ts   = '0;
            return;
        end
        busy = m_pend || m_held;
        if (clear) begin
            for (int i = 0; i < NUM_MON; i++) m_cnt[i] = 0;
            m_pend = 0;
            m_held = 0;
            m_rec  = '0;
        end else begin
            for (int i = 0; i < NUM_MON; i++) q[i] = (m_cnt[i] == THRESHOLD);
            if (!busy && q != '0) begin
                m_rec = '0;
                m_rec.mask[NUM_MON-1:0] = q;
                m_rec.ts[TS_W-1:0] = m_ts;
                for (int i = NUM_MON - 1; i >= 0; i--)
                    if (q[i]) m_rec.idx = 5'(i);
                m_pend = 1;
            end else if (m_pend && report_ready) begin
                m_pend = 0;
                m_held = 1;
            end
            if (!busy) begin
                for (int i = 0; i < NUM_MON; i++)
                    m_cnt[i] = block_in[i] ? ((m_cnt[i] < THRESHOLD) ? m_cnt[i] + 1 : THRESHOLD) : 0;
            end
        end
        m_ts = m_ts + 8'd1;
    endtask

    // One clock: advance the model at the edge, then compare all outputs.
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        chk("report_valid",  64'(report_valid),  64'(m_pend));
        chk("deadlock_flag", 64'(deadlock_flag), 64'(m_held));
        chk("report_idx",    64'(report_idx),    64'(m_rec.idx));
        chk("report_mask",   64'(report_mask),   64'(m_rec.mask[NUM_MON-1:0]));
        chk("report_ts",     64'(report_ts),     64'(m_rec.ts[TS_W-1:0]));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_MON; i++) m_cnt[i] = 0;
        m_pend = 0; m_held = 0; m_rec = '0; m_ts = '0;

        // Reset state
        reset = 1'b1;
        steps(2);
        chk("lit_reset_valid", 64'(report_valid), 64'd0);
        chk("lit_reset_flag",  64'(deadlock_flag), 64'd0);

        // Single monitor qualifies; accepted immediately
        reset = 1'b0;
        block_in = 4'b0100;
        report_ready = 1'b1;
        steps(4);
        chk("lit_no_early_valid", 64'(report_valid), 64'd0);
        step();
        chk("lit_t1_valid", 64'(report_valid), 64'd1);
        chk("lit_t1_idx",   64'(report_idx),   64'd2);
        chk("lit_t1_mask",  64'(report_mask),  64'h4);
        chk("lit_t1_ts",    64'(report_ts),    64'd4);
        step();
        chk("lit_t1_valid_drop", 64'(report_valid),  64'd0);
        chk("lit_t1_flag",       64'(deadlock_flag), 64'd1);
        steps(3);
        chk("lit_t1_flag_sticky", 64'(deadlock_flag), 64'd1);

        // Gap one cycle short of the threshold restarts the count
        block_in = 4'b0000;
        pulse_clear();
        chk("lit_clear_flag", 64'(deadlock_flag), 64'd0);
        block_in = 4'b0010; steps(3);
        block_in = 4'b0000; step();
        block_in = 4'b0010; steps(3);
        block_in = 4'b0000; steps(3);
        chk("lit_gap_no_valid", 64'(report_valid), 64'd0);

        // Two monitors together, consumer stalls for 10 cycles
        report_ready = 1'b0;
        block_in = 4'b1010;
        steps(5);
        chk("lit_t3_idx",  64'(report_idx),  64'd1);
        chk("lit_t3_mask", 64'(report_mask), 64'hA);
        steps(9);
        chk("lit_t3_still_valid", 64'(report_valid), 64'd1);
        report_ready = 1'b1;
        step();
        chk("lit_t3_accept_flag", 64'(deadlock_flag), 64'd1);

        // Held state ignores new qualifiers; clear restarts detection
        block_in = 4'b0001;
        steps(20);
        chk("lit_held_no_valid", 64'(report_valid), 64'd0);
        report_ready = 1'b0;
        pulse_clear();
        chk("lit_t4_flag_clr", 64'(deadlock_flag), 64'd0);
        steps(4);
        chk("lit_t4_not_yet", 64'(report_valid), 64'd0);
        step();
        chk("lit_t4_valid", 64'(report_valid), 64'd1);
        chk("lit_t4_idx",   64'(report_idx),   64'd0);

        // Clear coincident with the handshake aborts it
        report_ready = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        report_ready = 1'b0;
        chk("lit_t5_valid", 64'(report_valid),  64'd0);
        chk("lit_t5_flag",  64'(deadlock_flag), 64'd0);
        step();
        chk("lit_t5_flag_after", 64'(deadlock_flag), 64'd0);

        // Reset while a record is pending
        steps(4);
        reset = 1'b1;
        step();
        chk("lit_t6_valid", 64'(report_valid), 64'd0);
        chk("lit_t6_ts",    64'(report_ts),    64'd0);
        reset = 1'b0;
        steps(4);
        chk("lit_t6_full_count", 64'(report_valid), 64'd0);
        step();
        chk("lit_t6_valid_again", 64'(report_valid), 64'd1);

        // Randomized traffic; timestamp wraps several times
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_MON; i++)
                block_in[i] = ($urandom_range(0, 9) < 8);
            report_ready = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        clear = 1'b0;
        steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
